// File: rtl/m_col_packer.sv
// rtl/m_col_packer.sv - packs NSAMP samples into one flat column word with a column index
// Double-buffered: an assembly register fills while the output register waits on the lifting stage.
module m_col_packer #(
    parameter int SAMPLE_W = 9,
    parameter int NSAMP    = 16,
    parameter int COL_W    = 9,
    parameter int NCOLS    = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [SAMPLE_W-1:0]       din,
    input  logic                      din_valid,
    input  logic                      din_sof,
    output logic                      din_ready,
    output logic [SAMPLE_W*NSAMP-1:0] flat_o,
    output logic                      flat_valid,
    input  logic                      flat_ready,
    output logic [COL_W-1:0]          col_o,
    output logic                      col_last,
    output logic                      sof_err
);

    localparam int FLAT_W = SAMPLE_W * NSAMP;
    localparam int IDX_W  = $clog2(NSAMP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSAMP - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [FLAT_W-1:0]  asm_q, asm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   asm_col_q, asm_col_d;
    logic [FLAT_W-1:0]  out_q, out_d;
    logic [COL_W-1:0]   out_col_q, out_col_d;
    logic               out_valid_q, out_valid_d;
    logic               sof_err_q, sof_err_d;

    logic               accept;
    logic               out_hs;
    logic               out_free;
    logic               word_done;
    logic               xfer;
    logic [IDX_W-1:0]   slot;
    logic [FLAT_W-1:0]  asm_wr;

    assign accept    = din_valid && din_ready;
    assign out_hs    = out_valid_q && flat_ready;
    assign out_free  = !out_valid_q || out_hs;
    // A start-of-frame sample never completes a word, even when it lands at the last slot.
    assign word_done = accept && !din_sof && (idx_q == LAST_IDX);
    assign slot      = din_sof ? '0 : idx_q;
    assign xfer      = ((state_q == FILL) && word_done && out_free) ||
                       ((state_q == HOLD) && out_free);

    always_comb begin
        asm_wr = asm_q;
        for (int k = 0; k < NSAMP; k++) begin
            if (IDX_W'(k) == slot) begin
                asm_wr[k*SAMPLE_W +: SAMPLE_W] = din;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (word_done && !out_free) state_d = HOLD;
            HOLD: if (out_free)               state_d = FILL;
            default:                          state_d = FILL;
        endcase
    end

    // Output logic: readiness depends only on registered state
    always_comb begin
        din_ready = (state_q != HOLD);
    end

    always_comb begin
        asm_d       = asm_q;
        idx_d       = idx_q;
        asm_col_d   = asm_col_q;
        out_d       = out_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        sof_err_d   = sof_err_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            asm_d = asm_wr;
            if (din_sof) begin
                idx_d     = IDX_W'(1);
                asm_col_d = '0;
                if (idx_q != '0) begin
                    sof_err_d = 1'b1;
                end
            end else if (idx_q != LAST_IDX) begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (xfer) begin
            out_d       = (state_q == HOLD) ? asm_q : asm_wr;
            out_col_d   = asm_col_q;
            out_valid_d = 1'b1;
            asm_col_d   = (asm_col_q == LAST_COL) ? '0 : asm_col_q + COL_W'(1);
            idx_d       = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            asm_q       <= '0;
            idx_q       <= '0;
            asm_col_q   <= '0;
            out_q       <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            asm_col_q   <= asm_col_d;
            out_q       <= out_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            sof_err_q   <= sof_err_d;
        end
    end

    assign flat_o     = out_q;
    assign flat_valid = out_valid_q;
    assign col_o      = out_col_q;
    assign col_last   = out_valid_q && (out_col_q == LAST_COL);
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_m_col_packer.sv
// tb/tb_m_col_packer.sv - directed self-checking bench for m_col_packer
module tb_m_col_packer;

    logic         clock = 1'b0;
    logic         reset;
    logic [8:0]   din;
    logic         din_valid;
    logic         din_sof;
    logic         din_ready;
    logic [143:0] flat_o;
    logic         flat_valid;
    logic         flat_ready;
    logic [8:0]   col_o;
    logic         col_last;
    logic         sof_err;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    logic [143:0] wq[$];
    logic [8:0]   cq[$];
    logic         lq[$];

    m_col_packer dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .din_ready  (din_ready),
        .flat_o     (flat_o),
        .flat_valid (flat_valid),
        .flat_ready (flat_ready),
        .col_o      (col_o),
        .col_last   (col_last),
        .sof_err    (sof_err)
    );

    always #5 clock = ~clock;

    // Record every completed output handshake (inputs settle at the negedge)
    always @(negedge clock) begin
        #2;
        if (flat_valid && flat_ready) begin
            wq.push_back(flat_o);
            cq.push_back(col_o);
            lq.push_back(col_last);
        end
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] v, input logic s);
        int n;
        n = 0;
        din       = v;
        din_sof   = s;
        din_valid = 1'b1;
        if (!din_ready) stalls++;
        while (!din_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL push_timeout observed=%0d expected=<50", n);
        end
        @(negedge clock);
        din_valid = 1'b0;
        din_sof   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        wq.delete();
        cq.delete();
        lq.delete();
    endtask

    logic [143:0] exp_w0, exp_w1;
    int           nlast;

    initial begin
        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        flat_ready = 1'b0;
        #1;
        chk("rst_flat_valid", 144'(flat_valid), 144'd0);
        chk("rst_flat_o",     flat_o,           144'd0);
        chk("rst_col_o",      144'(col_o),      144'd0);
        chk("rst_col_last",   144'(col_last),   144'd0);
        chk("rst_sof_err",    144'(sof_err),    144'd0);
        chk("rst_din_ready",  144'(din_ready),  144'd1);
        @(negedge clock);
        reset = 1'b0;

        // Endpoints only: slot 0 and slot 15 set
        flat_ready = 1'b1;
        push(9'h1FF, 1'b0);
        for (int k = 1; k < 15; k++) push(9'h000, 1'b0);
        push(9'h1FF, 1'b0);
        chk("t1_valid", 144'(flat_valid), 144'd1);
        chk("t1_col",   144'(col_o),      144'd0);
        chk("t1_flat",  flat_o, 144'hFF8_0000000000_0000000000_0000000000_1FF);

        // Back-to-back streaming, no stalls allowed
        do_reset();
        stalls = 0;
        for (int k = 0; k < 16; k++) push(9'(k), 1'b0);
        for (int k = 0; k < 16; k++) push(9'(9'h100 + k), 1'b0);
        repeat (3) @(negedge clock);
        for (int k = 0; k < 16; k++) begin
            exp_w0[k*9 +: 9] = 9'(k);
            exp_w1[k*9 +: 9] = 9'(9'h100 + k);
        end
        chk("t2_stalls", 144'(stalls),   144'd0);
        chk("t2_nwords", 144'(wq.size()), 144'd2);
        if (wq.size() == 2) begin
            chk("t2_w0",       wq[0], exp_w0);
            chk("t2_w1",       wq[1], exp_w1);
            chk("t2_w1_slot3", 144'(wq[1][27 +: 9]), 144'h103);
            chk("t2_c0",       144'(cq[0]), 144'd0);
            chk("t2_c1",       144'(cq[1]), 144'd1);
        end

        // Backpressure: word0 held, word1 fills into HOLD
        do_reset();
        flat_ready = 1'b0;
        for (int k = 0; k < 16; k++) push(9'(k), 1'b0);
        chk("t3_w0_valid", 144'(flat_valid), 144'd1);
        for (int k = 0; k < 16; k++) push(9'(9'h100 + k), 1'b0);
        chk("t3_hold_ready", 144'(din_ready),  144'd0);
        chk("t3_hold_flat",  flat_o,           exp_w0);
        chk("t3_hold_col",   144'(col_o),      144'd0);
        chk("t3_hold_valid", 144'(flat_valid), 144'd1);
        flat_ready = 1'b1;
        @(negedge clock);
        flat_ready = 1'b0;
        chk("t3_w1_valid", 144'(flat_valid), 144'd1);
        chk("t3_w1_col",   144'(col_o),      144'd1);
        chk("t3_w1_flat",  flat_o,           exp_w1);
        chk("t3_ready",    144'(din_ready),  144'd1);
        flat_ready = 1'b1;
        repeat (2) @(negedge clock);

        // Column wrap over a full frame plus one
        do_reset();
        flat_ready = 1'b1;
        for (int w = 0; w < 257; w++)
            for (int k = 0; k < 16; k++) push(9'(w + k), 1'b0);
        repeat (3) @(negedge clock);
        chk("t4_nwords", 144'(wq.size()), 144'd257);
        if (wq.size() == 257) begin
            nlast = 0;
            foreach (lq[i]) if (lq[i]) nlast++;
            chk("t4_nlast",   144'(nlast),   144'd1);
            chk("t4_c255",    144'(cq[255]), 144'd255);
            chk("t4_last255", 144'(lq[255]), 144'd1);
            chk("t4_c256",    144'(cq[256]), 144'd0);
            chk("t4_c100",    144'(cq[100]), 144'd100);
        end

        // Mid-word start of frame: restart at slot 0 and column 0
        do_reset();
        flat_ready = 1'b1;
        for (int k = 0; k < 16; k++) push(9'(k), 1'b0);
        for (int k = 0; k < 5; k++) push(9'(9'h055 + k), 1'b0);
        chk("t5_err_before", 144'(sof_err), 144'd0);
        push(9'h0AA, 1'b1);
        chk("t5_err_after", 144'(sof_err), 144'd1);
        for (int k = 0; k < 15; k++) push(9'(9'h0C0 + k), 1'b0);
        exp_w0[8:0] = 9'h0AA;
        for (int k = 1; k < 16; k++) exp_w0[k*9 +: 9] = 9'(9'h0C0 + k - 1);
        chk("t5_valid", 144'(flat_valid), 144'd1);
        chk("t5_col",   144'(col_o),      144'd0);
        chk("t5_flat",  flat_o,           exp_w0);

        // Start of frame on the edge that would complete a word
        do_reset();
        flat_ready = 1'b1;
        for (int k = 0; k < 15; k++) push(9'(k), 1'b0);
        push(9'h1AB, 1'b1);
        chk("t6_no_word", 144'(flat_valid), 144'd0);
        chk("t6_err",     144'(sof_err),    144'd1);
        for (int k = 0; k < 15; k++) push(9'(9'h010 + k), 1'b0);
        exp_w1[8:0] = 9'h1AB;
        for (int k = 1; k < 16; k++) exp_w1[k*9 +: 9] = 9'(9'h010 + k - 1);
        chk("t6_flat", flat_o,        exp_w1);
        chk("t6_col",  144'(col_o),   144'd0);

        // Asynchronous reset mid-word with a word pending
        do_reset();
        flat_ready = 1'b0;
        for (int k = 0; k < 16; k++) push(9'(k + 1), 1'b0);
        for (int k = 0; k < 7; k++) push(9'(k), 1'b0);
        chk("t7_pre_valid", 144'(flat_valid), 144'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_async_valid", 144'(flat_valid), 144'd0);
        chk("t7_async_flat",  flat_o,           144'd0);
        chk("t7_async_col",   144'(col_o),      144'd0);
        chk("t7_async_ready", 144'(din_ready),  144'd1);
        @(negedge clock);
        reset      = 1'b0;
        flat_ready = 1'b1;
        for (int k = 0; k < 16; k++) push(9'(k), 1'b0);
        for (int k = 0; k < 16; k++) exp_w0[k*9 +: 9] = 9'(k);
        chk("t7_next_valid", 144'(flat_valid), 144'd1);
        chk("t7_next_col",   144'(col_o),      144'd0);
        chk("t7_next_flat",  flat_o,           exp_w0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
